shift_arbiter: RTL and testbench

- Shares one arithmetic/logical barrel shifter (16-bit data, 4-bit shift amount) between two requesters, A and B.
- Round-robin arbitration grants at most one request per cycle.
- The shifted result is registered into a single-entry output stage, with a tag naming the requester.
- Sits between the CPU datapath issue ports and writeback; downstream applies backpressure through out_ready.

---
 rtl/shift_arbiter.sv | 138 +++++++++++++
 tb/tb_shift_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters (A, B) share one barrel shifter through a
// round-robin arbiter; results land in a single-entry registered output
// stage tagged with the requester id.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready may depend on valid; a requester holds valid/payload stable
// until it sees ready. On the output side, out_data/out_tag are held stable
// while out_valid=1 and out_ready=0.
module shift_arbiter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_din,
    input  logic [SHW-1:0]   a_shamt,
    input  logic [1:0]       a_op,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_din,
    input  logic [SHW-1:0]   b_shamt,
    input  logic [1:0]       b_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // The output register occupancy is the whole FSM state; out_valid is the
    // externally visible copy of it.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic               tag_q;
    logic               rr_q;      // 0: A preferred on a tie, 1: B preferred

    logic               can_accept;
    logic               grant_a;
    logic               grant_b;
    logic               grant;

    logic [WIDTH-1:0]   sel_din;
    logic [SHW-1:0]     sel_shamt;
    logic [1:0]         sel_op;

    logic signed [WIDTH-1:0] sra_res;
    logic [2*WIDTH-1:0]      ror_wide;

    // Arbitration: grant only when the output stage can take a result; no
    // grant at all while reset is asserted.
    always_comb begin
        can_accept = (state_q == EMPTY) | out_ready;
        grant_a    = rst_n & can_accept & a_valid & (~b_valid | ~rr_q);
        grant_b    = rst_n & can_accept & b_valid & (~a_valid |  rr_q);
        grant      = grant_a | grant_b;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Operand select: B's operands only when B wins, otherwise A's.
    always_comb begin
        sel_din   = a_din;
        sel_shamt = a_shamt;
        sel_op    = a_op;
        if (grant_b) begin
            sel_din   = b_din;
            sel_shamt = b_shamt;
            sel_op    = b_op;
        end
    end

    // Shared barrel shifter; rotate uses a doubled operand so shamt=0 needs
    // no special case.
    always_comb begin
        sra_res  = $signed(sel_din) >>> sel_shamt;
        ror_wide = {sel_din, sel_din} >> sel_shamt;
        case (sel_op)
            OP_SLL:  data_d = sel_din << sel_shamt;
            OP_SRL:  data_d = sel_din >> sel_shamt;
            OP_SRA:  data_d = sra_res;
            OP_ROR:  data_d = ror_wide[WIDTH-1:0];
            default: data_d = sel_din;
        endcase
    end

    // Output stage FSM, result/tag registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            tag_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (grant) begin
                        state_q <= FULL;
                        data_q  <= data_d;
                        tag_q   <= grant_b;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (grant) begin
                            data_q <= data_d;
                            tag_q  <= grant_b;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
            // After a grant the other requester gets the next tie.
            if (grant) begin
                rr_q <= grant_a;
            end
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: hand-computed vectors for each shift
// op, arbitration order, backpressure and mid-operation reset.
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] a_din;
    logic [3:0]  a_shamt;
    logic [1:0]  a_op;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] b_din;
    logic [3:0]  b_shamt;
    logic [1:0]  b_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_tag;

    int n_vec;
    int n_err;

    shift_arbiter #(.WIDTH(16), .SHW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_din     (a_din),
        .a_shamt   (a_shamt),
        .a_op      (a_op),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_din     (b_din),
        .b_shamt   (b_shamt),
        .b_op      (b_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land just after the edge so outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational ready after input changes.
    task automatic settle();
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        a_valid = v;
        a_din   = d;
        a_shamt = s;
        a_op    = o;
    endtask

    task automatic drive_b(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        b_valid = v;
        b_din   = d;
        b_shamt = s;
        b_op    = o;
    endtask

    logic [15:0] tv_din [6];
    logic [3:0]  tv_sh  [6];
    logic [1:0]  tv_op  [6];
    logic [15:0] tv_exp [6];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive_a(1'b0, 16'h0, 4'h0, 2'b00);
        drive_b(1'b0, 16'h0, 4'h0, 2'b00);

        // Reset state
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        a_valid = 1'b1;
        b_valid = 1'b1;
        settle();
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // A: 1024 << 1
        drive_a(1'b1, 16'd1024, 4'd1, 2'b00);
        settle();
        check("sll_a_ready", a_ready, 1);
        check("sll_b_ready", b_ready, 0);
        step();
        check("sll_valid", out_valid, 1);
        check("sll_data", out_data, 16'd2048);
        check("sll_tag", out_tag, 0);

        // SRA / SRL on -1024
        drive_a(1'b1, 16'hFC00, 4'd5, 2'b10);
        settle();
        check("sra5_ready", a_ready, 1);
        step();
        check("sra5_data", out_data, 16'hFFE0);
        check("sra5_tag", out_tag, 0);
        drive_a(1'b1, 16'hFC00, 4'd11, 2'b10);
        step();
        check("sra11_data", out_data, 16'hFFFF);
        drive_a(1'b0, 16'h0, 4'd0, 2'b00);
        drive_b(1'b1, 16'hFC00, 4'd5, 2'b01);
        settle();
        check("srl_b_ready", b_ready, 1);
        step();
        check("srl_data", out_data, 16'h07E0);
        check("srl_tag", out_tag, 1);
        b_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);

        // Fairness from reset: both valid, out_ready=1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive_a(1'b1, 16'h0001, 4'd0, 2'b00);
        drive_b(1'b1, 16'h0002, 4'd0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("rr_a_ready_%0d", i), a_ready, (i % 2 == 0));
            check($sformatf("rr_b_ready_%0d", i), b_ready, (i % 2 == 1));
            step();
            check($sformatf("rr_valid_%0d", i), out_valid, 1);
            check($sformatf("rr_tag_%0d", i), out_tag, i % 2);
            check($sformatf("rr_data_%0d", i), out_data, (i % 2 == 0) ? 16'h0001 : 16'h0002);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        check("rr_drain", out_valid, 0);

        // Backpressure
        drive_b(1'b1, 16'h8001, 4'd1, 2'b11);
        settle();
        check("ror_b_ready", b_ready, 1);
        step();
        check("ror_data", out_data, 16'hC000);
        check("ror_tag", out_tag, 1);
        out_ready = 1'b0;
        drive_a(1'b1, 16'h0003, 4'd2, 2'b00);
        drive_b(1'b1, 16'h00F0, 4'd4, 2'b01);
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp_a_ready_%0d", i), a_ready, 0);
            check($sformatf("bp_b_ready_%0d", i), b_ready, 0);
            step();
            check($sformatf("bp_valid_%0d", i), out_valid, 1);
            check($sformatf("bp_data_%0d", i), out_data, 16'hC000);
            check($sformatf("bp_tag_%0d", i), out_tag, 1);
        end
        out_ready = 1'b1;
        settle();
        check("bp_rel_a_ready", a_ready, 1);
        check("bp_rel_b_ready", b_ready, 0);
        step();
        check("bp_next_data", out_data, 16'h000C);
        check("bp_next_tag", out_tag, 0);
        a_valid = 1'b0;
        settle();
        check("bp_b_ready", b_ready, 1);
        step();
        check("bp_b_data", out_data, 16'h000F);
        check("bp_b_tag", out_tag, 1);
        b_valid = 1'b0;
        step();
        check("bp_drain", out_valid, 0);

        // Boundary shift amounts
        tv_din[0] = 16'hA5A5; tv_sh[0] = 4'd0;  tv_op[0] = 2'b00; tv_exp[0] = 16'hA5A5;
        tv_din[1] = 16'hA5A5; tv_sh[1] = 4'd0;  tv_op[1] = 2'b01; tv_exp[1] = 16'hA5A5;
        tv_din[2] = 16'hA5A5; tv_sh[2] = 4'd0;  tv_op[2] = 2'b10; tv_exp[2] = 16'hA5A5;
        tv_din[3] = 16'hA5A5; tv_sh[3] = 4'd0;  tv_op[3] = 2'b11; tv_exp[3] = 16'hA5A5;
        tv_din[4] = 16'h8000; tv_sh[4] = 4'd15; tv_op[4] = 2'b10; tv_exp[4] = 16'hFFFF;
        tv_din[5] = 16'h0001; tv_sh[5] = 4'd15; tv_op[5] = 2'b00; tv_exp[5] = 16'h8000;
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, tv_din[i], tv_sh[i], tv_op[i]);
            step();
            check($sformatf("bnd_data_%0d", i), out_data, tv_exp[i]);
        end
        drive_a(1'b1, 16'h1234, 4'd4, 2'b11);
        step();
        check("ror4_data", out_data, 16'h4123);
        a_valid = 1'b0;
        step();

        // Reset mid-operation with a held result
        drive_a(1'b1, 16'h0001, 4'd0, 2'b00);
        step();
        a_valid = 1'b0;
        out_ready = 1'b0;
        check("hold_data", out_data, 16'h0001);
        rst_n = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        settle();
        check("mid_rst_a_ready", a_ready, 0);
        check("mid_rst_b_ready", b_ready, 0);
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_tag", out_tag, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        settle();
        check("post_rst_a_ready", a_ready, 1);
        check("post_rst_b_ready", b_ready, 0);
        step();
        check("post_rst_tag", out_tag, 0);
        check("post_rst_valid", out_valid, 1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
